booth_seq_mult: RTL and testbench
=================================

# booth_seq_mult

Sequential radix-2 Booth multiplier with a start/done handshake. It multiplies two signed two's-complement operands by stepping one shared add/subtract/shift datapath once per clock for WIDTH cycles. It is the sequenced, area-reduced counterpart of the combinational Booth multiplier, and sits between an operand producer and a result consumer that tolerate multi-cycle latency.

## Interface
Parameters:
- WIDTH, default 4: operand width in bits; must be ≥ 2. Product is 2*WIDTH bits.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a multiply; sampled only in IDLE or DONE.
- Data_A, input, WIDTH: signed multiplicand; latched on accepted start.
- Data_B, input, WIDTH: signed multiplier; latched on accepted start.
- busy, output, 1: high while in CALC.
- done, output, 1: one-cycle pulse, high in DONE.
- Product, output, 2*WIDTH: signed product; valid from done and held until the next accepted start completes.

## Operation
- State machine: IDLE, CALC, DONE.
  - IDLE, start=1: latch operands, go to CALC.
  - CALC: go to DONE after the WIDTH-th step.
  - DONE: always leaves after one cycle. With start=1 it latches new operands and goes to CALC; otherwise it goes to IDLE.
- Registers:
  - M: multiplicand, WIDTH+1 bits, sign-extended Data_A.
  - ACC: accumulator, WIDTH+1 bits, cleared on start.
  - Q: multiplier, WIDTH bits, loaded from Data_B.
  - q_1: previous bit, cleared on start.
  - cnt: step counter, clog2(WIDTH+1) bits, cleared on start.
- Each CALC step, selected by {Q[0], q_1}:
  - 01: ACC += M.
  - 10: ACC -= M.
  - 00 or 11: no change.
  - Then arithmetic-shift {ACC, Q, q_1} right by one, replicating ACC's MSB; increment cnt.
- ACC is WIDTH+1 bits so that negating M = -2^(WIDTH-1) does not overflow. Add/subtract wraps modulo 2^(WIDTH+1); by construction no information is lost.
- Result: Product <= {ACC[WIDTH-1:0], Q}, written on the edge entering DONE. Product is a full-precision signed result; -2^(WIDTH-1) × -2^(WIDTH-1) = +2^(2*WIDTH-2) fits.
- start while in CALC is ignored. The operands in flight are unaffected, and the requester must hold or re-issue start.
- Data_A and Data_B are don't-care except on the accepting edge.

## Timing
- Reset values (any state, including mid-CALC): state=IDLE, busy=0, done=0, Product=0, ACC/Q/q_1/cnt=0. Any operation in progress is discarded; no done pulse is produced for it.
- Latency: start is sampled at edge e0. busy is high from after e0 until after eWIDTH. done is high for exactly the one cycle after eWIDTH, i.e. WIDTH cycles after acceptance (4 for the default).
- Throughput: with start held high, a new multiply is accepted every WIDTH+1 cycles, because DONE doubles as an accept cycle.
- busy and done are never high together. Both are registered outputs derived from state with no combinational path from inputs.
- Product changes only on the edge entering DONE, or on reset.

## Structure
- Shared package/header booth_pkg:
  - state encodings: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - default WIDTH constant.
  - clog2 function for cnt sizing.
- One sub-module, booth_step: combinational single-step datapath.
  - inputs: ACC, Q, q_1, M.
  - outputs: next ACC, Q, q_1 after add/sub and arithmetic shift.
- Top module: FSM, counter and registers.

## Test plan
- WIDTH=4: Data_A=4'b1001 (-7), Data_B=4'b0111 (7), start one cycle → busy for 4 cycles, then done one cycle with Product=8'hCF (-49), held after done falls.
- WIDTH=4 corners:
  - -8 × -8 → Product=8'h40.
  - 7 × -8 → 8'hC8.
  - 0 × 5 → 8'h00.
  - -1 × -1 → 8'h01.
- start pulsed again in the 2nd CALC cycle with different operands → ignored; first result correct; no second done without a new start in IDLE/DONE.
- start held high with new operands presented in the DONE cycle (3 × 5) → back-to-back accept; next done exactly 5 cycles after the previous one, Product=8'h0F.
- rst asserted in the 3rd CALC cycle → next cycle busy=0, done=0, Product=0, state IDLE; a following -7 × 7 completes normally with 8'hCF.
- WIDTH=8: 127 × -128 → 16'hC080 after 8 cycles; 20-case random signed sweep against a reference model.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM encoding,
// default operand width and a constant-function clog2 for counter sizing.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Ceiling log2, at least 1 so a counter never collapses to zero width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M into ACC, then an
// arithmetic right shift of {ACC, Q, q_1}.
module booth_step #(
  parameter int unsigned WIDTH = booth_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_q_1})
      2'b01:   w_sum = i_acc + i_m;
      2'b10:   w_sum = i_acc - i_m;
      default: w_sum = i_acc;
    endcase
    o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
    o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    o_q_1 = i_q[0];
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one shared add/sub/shift step per
// clock for WIDTH clocks, with a start/busy/done handshake.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Data_A,
  input  logic [WIDTH-1:0]     Data_B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH:0]   r_m;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_q_1;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_acc_n;
  logic [WIDTH-1:0] w_q_n;
  logic             w_q_1_n;
  logic             w_accept;
  logic             w_last;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_acc (w_acc_n),
    .o_q   (w_q_n),
    .o_q_1 (w_q_1_n)
  );

  // DONE doubles as an accept cycle so held start gives back-to-back operation.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_accept    = start;
        w_state_nxt = start ? ST_CALC : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      Product <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q_1   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == ST_CALC);
      done    <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_m   <= {Data_A[WIDTH-1], Data_A};
        r_acc <= '0;
        r_q   <= Data_B;
        r_q_1 <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == ST_CALC) begin
        r_acc <= w_acc_n;
        r_q   <= w_q_n;
        r_q_1 <= w_q_1_n;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_last) Product <= {w_acc_n[WIDTH-1:0], w_q_n};
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and small random checks of booth_seq_mult at WIDTH=4 and WIDTH=8.
module tb_booth_seq_mult;

  logic        clk;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  booth_seq_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .Data_A(a4), .Data_B(b4),
    .busy(busy4), .done(done4), .Product(prod4)
  );

  booth_seq_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .Data_A(a8), .Data_B(b8),
    .busy(busy8), .done(done8), .Product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=4 multiply: busy for 4 cycles, done on the 4th edge after accept.
  task automatic mul4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp);
    int dcnt;
    a4 = a; b4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0; a4 = 4'hx; b4 = 4'hx;
    chk({tag, "_busy"}, 16'(busy4), 16'd1);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done4 || !busy4) dcnt++;
    end
    chk({tag, "_early"}, 16'(dcnt), 16'd0);
    tick();
    chk({tag, "_done"}, 16'({busy4, done4}), 16'b01);
    chk({tag, "_prod"}, 16'(prod4), 16'(exp));
    tick();
    chk({tag, "_hold"}, 16'({done4, prod4}), 16'({1'b0, exp}));
  endtask

  task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int dcnt;
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done8 || !busy8) dcnt++;
    end
    tick();
    chk({tag, "_seq"}, 16'({dcnt[7:0], 6'd0, busy8, done8}), 16'h0001);
    chk({tag, "_prod"}, prod8, exp);
  endtask

  initial begin
    int dcnt;
    logic signed [7:0]  ra, rb;
    logic signed [15:0] rp;
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst4", 16'({busy4, done4, prod4}), 16'h0);
    chk("rst8", 16'({busy8, done8}), 16'h0);
    chk("rst8_prod", prod8, 16'h0);
    tick();

    mul4("m7x7", 4'b1001, 4'b0111, 8'hCF);
    mul4("n8xn8", 4'h8, 4'h8, 8'h40);
    mul4("p7xn8", 4'h7, 4'h8, 8'hC8);
    mul4("zx5", 4'h0, 4'h5, 8'h00);
    mul4("n1xn1", 4'hF, 4'hF, 8'h01);

    // start during CALC is ignored
    a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a4 = 4'd5; b4 = 4'd5; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    chk("ign_busy", 16'({busy4, done4}), 16'b10);
    tick();
    chk("ign_done", 16'({busy4, done4}), 16'b01);
    chk("ign_prod", 16'(prod4), 16'h06);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done4 || busy4) dcnt++;
    end
    chk("ign_nodone", 16'(dcnt), 16'd0);

    // back-to-back accept from DONE with start held
    a4 = 4'b1001; b4 = 4'b0111; start4 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    tick();
    chk("b2b_done1", 16'({done4, prod4}), 16'h1CF);
    a4 = 4'd3; b4 = 4'd5;
    tick();
    start4 = 1'b0;
    chk("b2b_busy", 16'({busy4, done4}), 16'b10);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done4) dcnt++;
    end
    tick();
    chk("b2b_gap", 16'(dcnt), 16'd0);
    chk("b2b_done2", 16'({done4, prod4}), 16'h10F);
    tick();

    // reset in the 3rd CALC cycle discards the operation
    a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst", 16'({busy4, done4, prod4}), 16'h0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done4 || busy4) dcnt++;
    end
    chk("mrst_quiet", 16'(dcnt), 16'd0);
    mul4("post_rst", 4'b1001, 4'b0111, 8'hCF);

    mul8("w8_127xn128", 8'd127, 8'h80, 16'hC080);
    mul8("w8_n128sq", 8'h80, 8'h80, 16'h4000);
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = ra * rb;
      mul8($sformatf("rnd%0d", i), ra, rb, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
